// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the front-end stages.
// Holds the register-bus width, the fetch FSM encoding and the IF/ID entry layout.
// Pure declarations: no logic, no latency, no flow control.
package pipe_pkg;

  localparam int RegW = 32;

  typedef logic [RegW-1:0] reg_bus_t;

  localparam reg_bus_t ZeroWord   = 32'h0000_0000;
  localparam logic     RstEnable  = 1'b1;
  localparam reg_bus_t DefResetPc = 32'h0000_0000;

  // Fetch controller states; codes 5..7 are unused and fall back to S_IDLE.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_FULL  = 3'd3,
    S_DRAIN = 3'd4
  } fetch_state_t;

  // One IF/ID holding-buffer entry.
  typedef struct packed {
    reg_bus_t pc;
    reg_bus_t inst;
    logic     valid;
  } fetch_entry_t;

  // Instructions are word aligned; redirect targets drop their low two bits.
  function automatic reg_bus_t align_word(input reg_bus_t addr);
    return {addr[RegW-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry {pc, inst, valid} holding register presented to the IF/ID boundary.
// Latency: a load or clear takes effect on the next rising edge; outputs are flop-driven.
// Backpressure: none internally; the owner holds contents simply by asserting neither load nor clear.
module fetch_buf
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            ld,
  input  logic [RegW-1:0] ld_pc,
  input  logic [RegW-1:0] ld_inst,
  output logic [RegW-1:0] pc,
  output logic [RegW-1:0] inst,
  output logic            valid
);

  fetch_entry_t entry_q;

  // Clear beats load so a redirect can never let a stale word through;
  // a cleared entry reads as ZeroWord so the stage emits a clean bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      entry_q <= '{pc: ZeroWord, inst: ZeroWord, valid: 1'b0};
    end else if (clr) begin
      entry_q <= '{pc: ZeroWord, inst: ZeroWord, valid: 1'b0};
    end else if (ld) begin
      entry_q <= '{pc: ld_pc, inst: ld_inst, valid: 1'b1};
    end
  end

  assign pc    = entry_q.pc;
  assign inst  = entry_q.inst;
  assign valid = entry_q.valid;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests, buffers one word.
// Latency: with a zero-wait memory a request in cycle N is presented from N+2; one instruction per 3 cycles.
// Backpressure: stall_i freezes a full buffer and suppresses new requests; flush_i redirects and overrides stall.
module if_fetch
  import pipe_pkg::*;
#(
  parameter logic [RegW-1:0] RESET_PC = DefResetPc,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [RegW-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [RegW-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [RegW-1:0] imem_rdata_i,
  output logic [RegW-1:0] if_pc_o,
  output logic [RegW-1:0] if_inst_o,
  output logic            if_valid_o
);

  fetch_state_t state_q, state_d;
  reg_bus_t     pc_q, pc_d;
  reg_bus_t     req_pc_q, req_pc_d;
  logic         drop_q, drop_d;
  logic         req_q;
  logic         buf_clr, buf_ld;

  // Next-state logic. A flush is resolved first; it must account for any
  // access already granted, because that response will still come back
  // and has to be swallowed in S_DRAIN rather than loaded.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    drop_d   = drop_q;
    buf_clr  = 1'b0;
    buf_ld   = 1'b0;

    if (flush_i) begin
      pc_d    = align_word(redirect_pc_i);
      buf_clr = 1'b1;
      case (state_q)
        S_REQ: begin
          if (imem_gnt_i) begin
            state_d = S_DRAIN;
            drop_d  = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            state_d = S_REQ;
          end else begin
            state_d = S_DRAIN;
            drop_d  = 1'b1;
          end
        end
        S_DRAIN: begin
          // A repeated redirect only moves the target. If the stale word
          // lands in this same cycle nothing is outstanding any more, so
          // waiting on in S_DRAIN would wait for a response that never comes.
          if (imem_rvalid_i) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            state_d = S_DRAIN;
          end
        end
        default: state_d = S_REQ;  // S_IDLE, S_FULL and unused codes
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem_gnt_i) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_STEP;  // wraps naturally at 2^32
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            buf_ld  = 1'b1;
            state_d = S_FULL;
          end
        end
        S_FULL: begin
          // The consumer takes the entry at this edge unless it stalls.
          if (!stall_i) begin
            buf_clr = 1'b1;
            state_d = S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid_i) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control and address registers; the request strobe is registered from the
  // next state so every imem output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= ZeroWord;
      drop_q   <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
      req_q    <= (state_d == S_REQ);
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = pc_q;

  fetch_buf u_fetch_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (buf_clr),
    .ld      (buf_ld),
    .ld_pc   (req_pc_q),
    .ld_inst (imem_rdata_i),
    .pc      (if_pc_o),
    .inst    (if_inst_o),
    .valid   (if_valid_o)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus a randomized run
// against a program-order reference model with a latency-randomized memory.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;

  int tests_run    = 0;
  int tests_failed = 0;

  // Memory responder state
  logic        pend;
  logic [31:0] pend_addr;
  int          rv_wait;
  int          g_wait;
  int          gnt_lat_cfg = 0;
  int          rv_lat_cfg  = 0;
  bit          rand_lat    = 0;

  if_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_pc_o       (if_pc_o),
    .if_inst_o     (if_inst_o),
    .if_valid_o    (if_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F2E};
  endfunction

  function automatic int next_gnt();
    return rand_lat ? int'($urandom_range(0, 3)) : gnt_lat_cfg;
  endfunction

  function automatic int next_rv();
    return rand_lat ? int'($urandom_range(0, 3)) : rv_lat_cfg;
  endfunction

  // One clock: drive the memory side from the DUT's registered outputs,
  // take the edge, then settle 1 time unit past it for sampling.
  task automatic tick();
    logic [31:0] gaddr;
    gaddr         = imem_addr_o;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    if (pend) begin
      if (rv_wait == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(pend_addr);
      end else begin
        rv_wait = rv_wait - 1;
      end
    end else if (imem_req_o) begin
      if (g_wait == 0) imem_gnt_i = 1'b1;
      else g_wait = g_wait - 1;
    end
    @(posedge clk);
    if (imem_rvalid_i) pend = 1'b0;
    if (imem_gnt_i) begin
      pend      = 1'b1;
      pend_addr = gaddr;
      rv_wait   = next_rv();
      g_wait    = next_gnt();
    end
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    redirect_pc_i = 32'h0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    pend          = 1'b0;
    rv_wait       = 0;
    g_wait        = next_gnt();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; redirect_pc_i = 32'h0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    #2 rst = 1'b1;
    #1;
    tests_run++; if (imem_req_o !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b expected 0", imem_req_o); end
    tests_run++; if (imem_addr_o !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr_o); end
    tests_run++; if (if_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", if_valid_o); end
    tests_run++; if (if_pc_o !== 32'h0 || if_inst_o !== 32'h0) begin tests_failed++; $display("FAIL reset_if: got pc %h inst %h expected 0/0", if_pc_o, if_inst_o); end
  endtask

  task automatic test_seq();
    int          req_cyc[$];
    logic [31:0] req_addr[$];
    int          fv_cyc;
    logic [31:0] fv_pc, fv_inst;
    fv_cyc = -1; fv_pc = 32'h0; fv_inst = 32'h0;
    gnt_lat_cfg = 0; rv_lat_cfg = 0; rand_lat = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (imem_req_o) begin req_cyc.push_back(c); req_addr.push_back(imem_addr_o); end
      if (if_valid_o && fv_cyc < 0) begin fv_cyc = c; fv_pc = if_pc_o; fv_inst = if_inst_o; end
      tick();
    end
    tests_run++;
    if (req_cyc.size() < 3) begin
      tests_failed++; $display("FAIL seq_req_count: got %0d expected >=3", req_cyc.size());
    end else begin
      tests_run++; if (req_cyc[0] != 1) begin tests_failed++; $display("FAIL seq_first_req_cycle: got %0d expected 1", req_cyc[0]); end
      tests_run++; if (req_addr[0] !== 32'h0 || req_addr[1] !== 32'h4 || req_addr[2] !== 32'h8) begin
        tests_failed++; $display("FAIL seq_addrs: got %h %h %h expected 0 4 8", req_addr[0], req_addr[1], req_addr[2]); end
      tests_run++; if (req_cyc[1] - req_cyc[0] != 3 || req_cyc[2] - req_cyc[1] != 3) begin
        tests_failed++; $display("FAIL seq_spacing: got %0d %0d expected 3 3", req_cyc[1] - req_cyc[0], req_cyc[2] - req_cyc[1]); end
      tests_run++; if (fv_cyc - req_cyc[0] != 2) begin
        tests_failed++; $display("FAIL seq_latency: got %0d expected 2", fv_cyc - req_cyc[0]); end
    end
    tests_run++; if (fv_pc !== 32'h0 || fv_inst !== mem_word(32'h0)) begin
      tests_failed++; $display("FAIL seq_first_entry: got pc %h inst %h expected 00000000 %h", fv_pc, fv_inst, mem_word(32'h0)); end
  endtask

  task automatic test_gnt_delay();
    int high, bad_addr, grants;
    bit found;
    high = 0; bad_addr = 0; grants = 0; found = 0;
    gnt_lat_cfg = 0; rv_lat_cfg = 0; rand_lat = 0;
    do_reset();
    for (int c = 0; c < 10 && !if_valid_o; c++) tick();
    g_wait = 3;
    tick();
    for (int c = 0; c < 10 && grants == 0; c++) begin
      if (imem_req_o) begin high++; if (imem_addr_o !== 32'h4) bad_addr++; end
      tick();
      if (imem_gnt_i) grants++;
    end
    tests_run++; if (high != 4) begin tests_failed++; $display("FAIL gnt_req_held: got %0d cycles expected 4", high); end
    tests_run++; if (bad_addr != 0) begin tests_failed++; $display("FAIL gnt_addr_stable: got %0d bad cycles expected 0", bad_addr); end
    tests_run++; if (grants != 1) begin tests_failed++; $display("FAIL gnt_count: got %0d expected 1", grants); end
    tests_run++; if (imem_req_o !== 1'b0) begin tests_failed++; $display("FAIL gnt_req_drop: got %b expected 0", imem_req_o); end
    for (int c = 0; c < 10 && !found; c++) begin
      if (imem_req_o) found = 1; else tick();
    end
    tests_run++; if (!found || imem_addr_o !== 32'h8) begin
      tests_failed++; $display("FAIL gnt_next_addr: got req %b addr %h expected 1 00000008", found, imem_addr_o); end
  endtask

  task automatic test_stall();
    bit found;
    found = 0;
    gnt_lat_cfg = 0; rv_lat_cfg = 0; rand_lat = 0;
    do_reset();
    for (int c = 0; c < 40 && !found; c++) begin
      if (if_valid_o && if_pc_o === 32'h10) found = 1; else tick();
    end
    tests_run++; if (!found || if_inst_o !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL stall_setup: got found %b inst %h expected 1 deadbeef", found, if_inst_o); end
    stall_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests_run++;
      if (if_valid_o !== 1'b1 || if_pc_o !== 32'h10 || if_inst_o !== 32'hDEAD_BEEF || imem_req_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold_%0d: got v %b pc %h inst %h req %b expected 1 00000010 deadbeef 0",
                 c, if_valid_o, if_pc_o, if_inst_o, imem_req_o);
      end
    end
    stall_i = 1'b0;
    tick();
    tests_run++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h14 || if_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL stall_release: got req %b addr %h v %b expected 1 00000014 0", imem_req_o, imem_addr_o, if_valid_o); end
  endtask

  task automatic test_flush_wait();
    bit          got, stale, have_addr;
    logic [31:0] first_addr, got_pc, got_inst;
    got = 0; stale = 0; have_addr = 0; first_addr = 32'h0; got_pc = 32'h0; got_inst = 32'h0;
    gnt_lat_cfg = 0; rv_lat_cfg = 2; rand_lat = 0;
    do_reset();
    tick();  // IDLE -> REQ
    tick();  // granted -> WAIT, response two cycles away
    flush_i = 1'b1; redirect_pc_i = 32'h203;
    tick();
    flush_i = 1'b0; redirect_pc_i = 32'h0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (if_valid_o) begin
        if (if_pc_o !== 32'h200) stale = 1;
        else begin got = 1; got_pc = if_pc_o; got_inst = if_inst_o; end
      end
      if (!got) begin
        if (imem_req_o && !have_addr) begin have_addr = 1; first_addr = imem_addr_o; end
        tick();
      end
    end
    tests_run++; if (stale) begin tests_failed++; $display("FAIL flush_stale_visible: got stale entry expected none"); end
    tests_run++; if (!have_addr || first_addr !== 32'h200) begin
      tests_failed++; $display("FAIL flush_req_addr: got %h expected 00000200", first_addr); end
    tests_run++; if (!got || got_pc !== 32'h200 || got_inst !== mem_word(32'h200)) begin
      tests_failed++; $display("FAIL flush_entry: got pc %h inst %h expected 00000200 %h", got_pc, got_inst, mem_word(32'h200)); end
    rv_lat_cfg = 0;
  endtask

  task automatic test_flush_stall();
    gnt_lat_cfg = 0; rv_lat_cfg = 0; rand_lat = 0;
    do_reset();
    for (int c = 0; c < 10 && !if_valid_o; c++) tick();
    stall_i = 1'b1; flush_i = 1'b1; redirect_pc_i = 32'h1000;
    tick();
    stall_i = 1'b0; flush_i = 1'b0; redirect_pc_i = 32'h0;
    tests_run++; if (if_valid_o !== 1'b0 || if_pc_o !== 32'h0 || if_inst_o !== 32'h0) begin
      tests_failed++; $display("FAIL flush_stall_bubble: got v %b pc %h inst %h expected 0 0 0", if_valid_o, if_pc_o, if_inst_o); end
    tests_run++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h1000) begin
      tests_failed++; $display("FAIL flush_stall_req: got req %b addr %h expected 1 00001000", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_wrap();
    gnt_lat_cfg = 0; rv_lat_cfg = 0; rand_lat = 0;
    do_reset();
    flush_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    flush_i = 1'b0; redirect_pc_i = 32'h0;
    tests_run++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin
      tests_failed++; $display("FAIL wrap_req: got req %b addr %h expected 1 fffffffc", imem_req_o, imem_addr_o); end
    tick();
    tick();
    tests_run++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'hFFFF_FFFC || if_inst_o !== mem_word(32'hFFFF_FFFC)) begin
      tests_failed++; $display("FAIL wrap_entry: got v %b pc %h inst %h expected 1 fffffffc %h",
                               if_valid_o, if_pc_o, if_inst_o, mem_word(32'hFFFF_FFFC)); end
    tick();
    tests_run++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      tests_failed++; $display("FAIL wrap_next: got req %b addr %h expected 1 00000000", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_async_reset();
    gnt_lat_cfg = 0; rv_lat_cfg = 6; rand_lat = 0;
    do_reset();
    tick();  // -> REQ
    tick();  // granted -> WAIT, pc advanced
    tests_run++; if (imem_addr_o !== 32'h4 || imem_req_o !== 1'b0) begin
      tests_failed++; $display("FAIL arst_pre: got req %b addr %h expected 0 00000004", imem_req_o, imem_addr_o); end
    #3 rst = 1'b1;
    pend = 1'b0;
    #1;
    tests_run++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0 || if_valid_o !== 1'b0 || if_pc_o !== 32'h0 || if_inst_o !== 32'h0) begin
      tests_failed++; $display("FAIL arst_immediate: got req %b addr %h v %b pc %h inst %h expected all zero",
                               imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_inst_o); end
    @(posedge clk);
    #1 rst = 1'b0;
    rv_lat_cfg = 0;
    g_wait = 0;
    tick();
    tests_run++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      tests_failed++; $display("FAIL arst_restart: got req %b addr %h expected 1 00000000", imem_req_o, imem_addr_o); end
  endtask

  // Randomized run: the model tracks only the program-order address of the
  // next instruction the consumer should see; memory latencies are random.
  task automatic test_random();
    logic [31:0] exp_pc, held_addr;
    bit          hold_chk, req_before;
    int          consumed, flushes;
    exp_pc = 32'h0; held_addr = 32'h0; hold_chk = 0; req_before = 0; consumed = 0; flushes = 0;
    rand_lat = 1;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      tests_run++;
      if (if_valid_o) begin
        if (if_pc_o !== exp_pc || if_inst_o !== mem_word(exp_pc)) begin
          tests_failed++; $display("FAIL rand_entry cyc %0d: got pc %h inst %h expected %h %h", c, if_pc_o, if_inst_o, exp_pc, mem_word(exp_pc));
        end
      end else if (if_pc_o !== 32'h0 || if_inst_o !== 32'h0) begin
        tests_failed++; $display("FAIL rand_bubble cyc %0d: got pc %h inst %h expected 0 0", c, if_pc_o, if_inst_o);
      end
      if (hold_chk) begin
        tests_run++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== held_addr) begin
          tests_failed++; $display("FAIL rand_req_hold cyc %0d: got req %b addr %h expected 1 %h", c, imem_req_o, imem_addr_o, held_addr);
        end
      end
      stall_i       = ($urandom_range(0, 3) == 0);
      flush_i       = ($urandom_range(0, 24) == 0);
      redirect_pc_i = $urandom;
      if (flush_i) begin
        exp_pc = redirect_pc_i & 32'hFFFF_FFFC;
        flushes++;
      end else if (if_valid_o && !stall_i) begin
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      held_addr  = imem_addr_o;
      req_before = imem_req_o;
      tick();
      hold_chk = req_before && !imem_gnt_i && !flush_i;
    end
    stall_i = 1'b0; flush_i = 1'b0; redirect_pc_i = 32'h0;
    rand_lat = 0;
    tests_run++; if (consumed < 20) begin
      tests_failed++; $display("FAIL rand_progress: got %0d consumed expected >=20 (flushes %0d)", consumed, flushes); end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_gnt_delay();
    test_stall();
    test_flush_wait();
    test_flush_stall();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
